// File: rtl/aes_key_expander.sv
// AES-128 key expander: expands a 128-bit cipher key into the 44-word key
// schedule at one word per cycle, keeps it in a register file and serves
// any of the 11 round keys through a registered read port.
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   start_in, key_in   expansion request and cipher key (sampled in IDLE)
//   busy_out           high while words w4..w43 are being generated
//   done_out           one-cycle pulse once the schedule is complete
//   keys_valid_out     stored schedule matches the last accepted key
//   rd_round_in        round index 0..10 (11..15 read as zero)
//   rd_key_out         {w[4r],w[4r+1],w[4r+2],w[4r+3]}, one cycle after index
module aes_key_expander (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         keys_valid_out,
  input  logic [3:0]   rd_round_in,
  output logic [127:0] rd_key_out
);

  localparam int unsigned NUM_WORDS  = 44;
  localparam int unsigned LAST_ROUND = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [31:0] r_w [NUM_WORDS];

  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic [7:0]  w_rcon;
  logic [5:0]  w_rd_base;

  // Round constant for word index i = 4*k, indexed by k = 1..10.
  always_comb begin
    w_rcon = 8'h00;
    case (r_idx[5:2])
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Next schedule word w[i] from w[i-1] and w[i-4].
  always_comb begin
    w_prev = r_w[r_idx - 6'd1];
    w_back = r_w[r_idx - 6'd4];
    w_rot  = {w_prev[23:0], w_prev[31:24]};
    w_sub  = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]};
    w_temp = (r_idx[1:0] == 2'd0) ? (w_sub ^ {w_rcon, 24'h000000}) : w_prev;
    w_new  = w_back ^ w_temp;
  end

  assign w_rd_base = {rd_round_in, 2'b00};

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= S_IDLE;
      r_idx          <= 6'd0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      keys_valid_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state        <= S_EXPAND;
            r_idx          <= 6'd4;
            busy_out       <= 1'b1;
            keys_valid_out <= 1'b0;
          end
        end
        S_EXPAND: begin
          r_idx <= r_idx + 6'd1;
          if (r_idx == 6'(NUM_WORDS - 1)) begin
            r_state        <= S_DONE;
            busy_out       <= 1'b0;
            done_out       <= 1'b1;
            keys_valid_out <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Schedule storage; intentionally not reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (r_state == S_IDLE && start_in) begin
        r_w[0] <= key_in[127:96];
        r_w[1] <= key_in[95:64];
        r_w[2] <= key_in[63:32];
        r_w[3] <= key_in[31:0];
      end else if (r_state == S_EXPAND) begin
        r_w[r_idx] <= w_new;
      end
    end
  end

  // Registered round-key read; out-of-range rounds read as zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_key_out <= 128'h0;
    end else if (rd_round_in <= 4'(LAST_ROUND)) begin
      rd_key_out <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                     r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
    end else begin
      rd_key_out <= 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: reference schedule built from a GF(2^8)-derived
// S-box, timing of busy/done/valid, start-ignore, mid-run reset, read port.
module tb_aes_key_expander;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic [127:0] key_in;
  logic         busy_out;
  logic         done_out;
  logic         keys_valid_out;
  logic [3:0]   rd_round_in;
  logic [127:0] rd_key_out;

  always #5 clk_in = ~clk_in;

  aes_key_expander dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .key_in         (key_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .keys_valid_out (keys_valid_out),
    .rd_round_in    (rd_round_in),
    .rd_key_out     (rd_key_out)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  int   busy_cnt;
  int   done_at;
  int   done_cnt;
  logic valid_t1;
  logic valid_t41;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start an expansion at the next edge and observe 45 cycles afterwards.
  task automatic run_expand(input logic [127:0] key, input logic inject, input logic [127:0] key2);
    start_in = 1'b1;
    key_in   = key;
    tick();
    start_in  = 1'b0;
    key_in    = rand128();
    busy_cnt  = 0;
    done_at   = 0;
    done_cnt  = 0;
    valid_t1  = keys_valid_out;
    valid_t41 = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (busy_out) busy_cnt++;
      if (done_out) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (n == 41) valid_t41 = keys_valid_out;
      start_in = inject && (n == 5 || n == 20);
      if (inject) key_in = key2;
      tick();
    end
    start_in = 1'b0;
    check("busy_cycles", 128'(busy_cnt), 128'd40);
    check("done_cycle", 128'(done_at), 128'd41);
    check("done_pulses", 128'(done_cnt), 128'd1);
    check("valid_t1", 128'(valid_t1), 128'd0);
    check("valid_t41", 128'(valid_t41), 128'd1);
    check("valid_hold", 128'(keys_valid_out), 128'd1);
  endtask

  // Back-to-back sweep of rounds 0..10 against the model.
  task automatic sweep(input string tag);
    logic [127:0] prev;
    rd_round_in = 4'd0;
    tick();
    check($sformatf("%s_r0", tag), rd_key_out, exp_rk[0]);
    prev = rd_key_out;
    for (int r = 1; r <= 10; r++) begin
      rd_round_in = 4'(r);
      #1;
      check($sformatf("%s_hold%0d", tag, r), rd_key_out, prev);
      tick();
      check($sformatf("%s_r%0d", tag, r), rd_key_out, exp_rk[r]);
      prev = rd_key_out;
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] v);
    rd_round_in = r;
    tick();
    v = rd_key_out;
  endtask

  initial begin
    logic [127:0] ka;
    logic [127:0] kb;
    logic [127:0] v;
    int           busy_seen;
    int           done_seen;

    rst_in      = 1'b1;
    start_in    = 1'b0;
    key_in      = 128'h0;
    rd_round_in = 4'd0;
    build_sbox();
    repeat (3) tick();
    check("rst_busy", 128'(busy_out), 128'd0);
    check("rst_done", 128'(done_out), 128'd0);
    check("rst_valid", 128'(keys_valid_out), 128'd0);
    check("rst_rdkey", rd_key_out, 128'h0);
    rst_in = 1'b0;
    tick();

    // FIPS-197 key
    ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(ka);
    check("model_fips_r1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_expand(ka, 1'b0, 128'h0);
    read_round(4'd0, v);  check("fips_r0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_round(4'd1, v);  check("fips_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_round(4'd10, v); check("fips_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep("fips");

    // All-zero key, restart from a valid schedule
    run_expand(128'h0, 1'b0, 128'h0);
    read_round(4'd1, v);  check("zero_r1", v, 128'h62636363626363636263636362636363);
    read_round(4'd10, v); check("zero_r10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Out-of-range rounds read zero
    read_round(4'd11, v); check("rd_r11", v, 128'h0);
    read_round(4'd15, v); check("rd_r15", v, 128'h0);

    // Starts during expansion are ignored
    ka = rand128();
    kb = rand128();
    model(ka);
    run_expand(ka, 1'b1, kb);
    sweep("inject");

    // Reset at T+17
    ka = rand128();
    start_in = 1'b1;
    key_in   = ka;
    tick();
    start_in = 1'b0;
    for (int n = 1; n < 17; n++) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("midrst_busy", 128'(busy_out), 128'd0);
    check("midrst_valid", 128'(keys_valid_out), 128'd0);
    check("midrst_done", 128'(done_out), 128'd0);
    busy_seen = 0;
    done_seen = 0;
    for (int n = 0; n < 45; n++) begin
      if (busy_out) busy_seen++;
      if (done_out) done_seen++;
      tick();
    end
    check("midrst_no_busy", 128'(busy_seen), 128'd0);
    check("midrst_no_done", 128'(done_seen), 128'd0);
    model(ka);
    run_expand(ka, 1'b0, 128'h0);
    sweep("after_rst");

    // Simultaneous reset and start: reset wins
    rst_in   = 1'b1;
    start_in = 1'b1;
    key_in   = rand128();
    tick();
    rst_in   = 1'b0;
    start_in = 1'b0;
    check("rststart_valid", 128'(keys_valid_out), 128'd0);
    tick();
    check("rststart_busy", 128'(busy_out), 128'd0);

    // Random keys
    for (int k = 0; k < 4; k++) begin
      ka = rand128();
      model(ka);
      run_expand(ka, 1'b0, 128'h0);
      sweep($sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream stage of the AES round engine inside the AES coprocessor.
- Takes a 128-bit cipher key and iteratively generates the full AES-128 key schedule, one word per cycle: 44 words, i.e. 11 round keys.
- Stores the schedule in an internal register file and serves any round key over a registered read port, which the round engine indexes by round number.
- Signals completion with a one-cycle pulse and holds a valid flag until the next expansion or reset.

Parameters:
None (AES-128 only; Nk=4, Nr=10 fixed).

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  synchronous active-high reset
start_in  input  1  request expansion of key_in; sampled only in IDLE
key_in  input  128  cipher key, byte 0 in [127:120]; sampled the cycle start_in is accepted
busy_out  output  1  high while expansion in progress
done_out  output  1  one-cycle pulse when schedule complete
keys_valid_out  output  1  high while stored schedule corresponds to last accepted key
rd_round_in  input  4  round key index 0..10
rd_key_out  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous, active-high.
- Reset values: busy_out=0, done_out=0, keys_valid_out=0, rd_key_out=0, state=IDLE, word index=0. Schedule storage is not reset; contents are don't-care.
- States:
  - IDLE: start_in=1 at edge T latches key_in into w0..w3, sets i=4, clears keys_valid_out, goes to EXPAND.
  - EXPAND: each cycle computes w[i]. temp=w[i-1]. If i mod 4==0, temp=SubWord(RotWord(temp)) xor {Rcon[i/4],24'h0}. w[i]=w[i-4] xor temp, written at end of cycle, then i++. After writing w43, goes to DONE.
  - DONE: one cycle, then IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord applies the FIPS-197 forward S-box (combinational ROM) to each byte. RotWord is a left byte rotate: [31:24] moves to [7:0].
- Timing relative to accepting edge T:
  - busy_out high in cycles T+1..T+40, exactly 40 cycles.
  - done_out high in cycle T+41 only.
  - keys_valid_out goes high in cycle T+41 and stays high.
  - Earliest next start is accepted at the edge ending cycle T+42 (back in IDLE).
- start_in while busy or in DONE is ignored; no queuing. key_in changes during EXPAND have no effect.
- start_in in IDLE with keys_valid_out=1 performs a full restart; keys_valid_out drops after edge T.
- Read port:
  - rd_key_out registered, 1-cycle latency: rd_round_in sampled at edge E, data valid after E.
  - rd_round_in 11..15 returns 128'h0.
  - Reads while busy return current storage (partially updated); no guarantee, and consumers must gate on keys_valid_out.
- Reset mid-expansion returns to IDLE the next cycle with busy_out=0 and keys_valid_out=0. No done_out pulse.
- Simultaneous rst_in and start_in: reset wins.

Test Plan:
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c, start_in for 1 cycle -> busy_out high exactly 40 cycles, done_out pulse at T+41. Reads: round 0 = 2b7e151628aed2a6abf7158809cf4f3c, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 128'h0 -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; keys_valid_out=1 after done.
- start_in with a second key asserted at T+5 and T+20 of an expansion -> ignored; total busy stays 40 cycles; schedule matches the first key only.
- After a valid schedule, start a new key -> keys_valid_out low from T+1, high at T+41; rd_round_in=10 returns the new key's round 10.
- rst_in asserted at T+17 -> next cycle busy_out=0, keys_valid_out=0, no done_out; a subsequent start expands correctly.
- rd_round_in=11 and 15 -> rd_key_out=0 one cycle later; sweep rd_round_in 0..10 back-to-back -> each value appears exactly one cycle after its index.
